// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// AxiLiteMaster (module axi_lite_master)
//
// Purpose: turns single read/write commands into AXI4-Lite transactions. Only
// one transaction is in flight at a time. Each finished transaction is
// returned on a response handshake. A sticky timeout flag warns when the
// slave is slow, but the transaction still runs to completion.
//
// Ports:
//   axi_aclk, axi_areset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write, cmd_addr,        command: direction, byte address,
//   cmd_wdata, cmd_wstrb        write data and strobes (unused for reads)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_resp,        response: read data (0 for writes),
//   rsp_write                   AXI response code, echo of the direction
//   M_AXI_aw*/w*/b*/ar*/r*      AXI4-Lite master channels
//   timeout                     sticky flag for the current transaction
//   txn_count                   number of completed responses (wraps)
// ---------------------------------------------------------------------------
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 40,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  axi_aclk,
   input  logic                  axi_areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_write,
   output logic [ADDR_WIDTH-1:0] M_AXI_awaddr,
   output logic [2:0]            M_AXI_awprot,
   output logic                  M_AXI_awvalid,
   input  logic                  M_AXI_awready,
   output logic [31:0]           M_AXI_wdata,
   output logic [3:0]            M_AXI_wstrb,
   output logic                  M_AXI_wvalid,
   input  logic                  M_AXI_wready,
   input  logic [1:0]            M_AXI_bresp,
   input  logic                  M_AXI_bvalid,
   output logic                  M_AXI_bready,
   output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
   output logic [2:0]            M_AXI_arprot,
   output logic                  M_AXI_arvalid,
   input  logic                  M_AXI_arready,
   input  logic [31:0]           M_AXI_rdata,
   input  logic [1:0]            M_AXI_rresp,
   input  logic                  M_AXI_rvalid,
   output logic                  M_AXI_rready,
   output logic                  timeout,
   output logic [15:0]           txn_count
);

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  write_q;
   logic                  awValid_q;
   logic                  wValid_q;
   logic                  bReady_q;
   logic                  arValid_q;
   logic                  rReady_q;
   logic                  rspValid_q;
   logic [31:0]           rspRdata_q;
   logic [1:0]            rspResp_q;
   logic                  timeout_q;
   logic [15:0]           txnCount_q;
   logic [15:0]           cycleCnt_q;
   logic [15:0]           cycleCnt_d;
   logic                  cmdAccept;
   logic                  awDone;
   logic                  wDone;

   // cmd_ready comes straight from the state so that the very first cycle
   // after reset already offers it; reset itself masks it to 0.
   assign cmd_ready = (state_q == IDLE) && !axi_areset;
   assign cmdAccept = cmd_valid && cmd_ready;

   // A write channel counts as done when its handshake happens this cycle or
   // its valid has already dropped after an earlier handshake.
   assign awDone = !awValid_q || M_AXI_awready;
   assign wDone  = !wValid_q  || M_AXI_wready;

   // The wait counter only runs while the slave owns the transaction, and it
   // saturates so that a stuck slave can never wrap it back below the limit.
   always_comb begin
      cycleCnt_d = cycleCnt_q;
      if ((state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA}) && (cycleCnt_q != 16'hFFFF)) begin
         cycleCnt_d = cycleCnt_q + 16'd1;
      end
   end

   // Main transaction FSM. Every output is a register updated here. A new
   // accept clears the counter and timeout after the generic update, and
   // the later assignment takes priority.
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         write_q    <= 1'b0;
         awValid_q  <= 1'b0;
         wValid_q   <= 1'b0;
         bReady_q   <= 1'b0;
         arValid_q  <= 1'b0;
         rReady_q   <= 1'b0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspResp_q  <= '0;
         timeout_q  <= 1'b0;
         txnCount_q <= '0;
         cycleCnt_q <= '0;
      end else begin
         cycleCnt_q <= cycleCnt_d;
         if (cycleCnt_d >= TIMEOUT_LIMIT) begin
            timeout_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (cmdAccept) begin
                  addr_q     <= cmd_addr;
                  wdata_q    <= cmd_wdata;
                  wstrb_q    <= cmd_wstrb;
                  write_q    <= cmd_write;
                  cycleCnt_q <= '0;
                  timeout_q  <= 1'b0;
                  if (cmd_write) begin
                     awValid_q <= 1'b1;
                     wValid_q  <= 1'b1;
                     state_q   <= WR;
                  end else begin
                     arValid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            WR: begin
               if (awValid_q && M_AXI_awready) begin
                  awValid_q <= 1'b0;
               end
               if (wValid_q && M_AXI_wready) begin
                  wValid_q <= 1'b0;
               end
               if (awDone && wDone) begin
                  bReady_q <= 1'b1;
                  state_q  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (M_AXI_bvalid) begin
                  bReady_q   <= 1'b0;
                  rspResp_q  <= M_AXI_bresp;
                  rspRdata_q <= '0;
                  rspValid_q <= 1'b1;
                  state_q    <= RSP;
               end
            end
            RD_ADDR: begin
               if (M_AXI_arready) begin
                  arValid_q <= 1'b0;
                  rReady_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (M_AXI_rvalid) begin
                  rReady_q   <= 1'b0;
                  rspRdata_q <= M_AXI_rdata;
                  rspResp_q  <= M_AXI_rresp;
                  rspValid_q <= 1'b1;
                  state_q    <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  txnCount_q <= txnCount_q + 16'd1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign M_AXI_awaddr  = addr_q;
   assign M_AXI_awprot  = 3'b000;
   assign M_AXI_awvalid = awValid_q;
   assign M_AXI_wdata   = wdata_q;
   assign M_AXI_wstrb   = wstrb_q;
   assign M_AXI_wvalid  = wValid_q;
   assign M_AXI_bready  = bReady_q;
   assign M_AXI_araddr  = addr_q;
   assign M_AXI_arprot  = 3'b000;
   assign M_AXI_arvalid = arValid_q;
   assign M_AXI_rready  = rReady_q;
   assign rsp_valid     = rspValid_q;
   assign rsp_rdata     = rspRdata_q;
   assign rsp_resp      = rspResp_q;
   assign rsp_write     = write_q;
   assign timeout       = timeout_q;
   assign txn_count     = txnCount_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// Directed testbench for axi_lite_master. The bench plays the command source,
// the response sink and a small register-file AXI slave. It steps one clock
// at a time and checks outputs 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

   logic        axi_aclk;
   logic        axi_areset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [39:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_write;
   logic [39:0] M_AXI_awaddr;
   logic [2:0]  M_AXI_awprot;
   logic        M_AXI_awvalid;
   logic        M_AXI_awready;
   logic [31:0] M_AXI_wdata;
   logic [3:0]  M_AXI_wstrb;
   logic        M_AXI_wvalid;
   logic        M_AXI_wready;
   logic [1:0]  M_AXI_bresp;
   logic        M_AXI_bvalid;
   logic        M_AXI_bready;
   logic [39:0] M_AXI_araddr;
   logic [2:0]  M_AXI_arprot;
   logic        M_AXI_arvalid;
   logic        M_AXI_arready;
   logic [31:0] M_AXI_rdata;
   logic [1:0]  M_AXI_rresp;
   logic        M_AXI_rvalid;
   logic        M_AXI_rready;
   logic        timeout;
   logic [15:0] txn_count;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [15:0] expTxn      = 16'd0;
   logic [31:0] rf [0:1];
   logic [39:0] slaveAddr;

   axi_lite_master #(
      .ADDR_WIDTH(40),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .axi_aclk(axi_aclk),
      .axi_areset(axi_areset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp),
      .rsp_write(rsp_write),
      .M_AXI_awaddr(M_AXI_awaddr),
      .M_AXI_awprot(M_AXI_awprot),
      .M_AXI_awvalid(M_AXI_awvalid),
      .M_AXI_awready(M_AXI_awready),
      .M_AXI_wdata(M_AXI_wdata),
      .M_AXI_wstrb(M_AXI_wstrb),
      .M_AXI_wvalid(M_AXI_wvalid),
      .M_AXI_wready(M_AXI_wready),
      .M_AXI_bresp(M_AXI_bresp),
      .M_AXI_bvalid(M_AXI_bvalid),
      .M_AXI_bready(M_AXI_bready),
      .M_AXI_araddr(M_AXI_araddr),
      .M_AXI_arprot(M_AXI_arprot),
      .M_AXI_arvalid(M_AXI_arvalid),
      .M_AXI_arready(M_AXI_arready),
      .M_AXI_rdata(M_AXI_rdata),
      .M_AXI_rresp(M_AXI_rresp),
      .M_AXI_rvalid(M_AXI_rvalid),
      .M_AXI_rready(M_AXI_rready),
      .timeout(timeout),
      .txn_count(txn_count)
   );

   // 10-unit clock period.
   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge axi_aclk);
      #1;
   endtask

   // Drive the command port.
   task automatic applyStimulus(input logic valid, input logic write, input logic [39:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      cmd_valid = valid;
      cmd_write = write;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_wstrb = wstrb;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Write with a zero-wait slave and rsp_ready raised once the response shows.
   task automatic doWrite(input logic [39:0] addr, input logic [31:0] data, input logic [3:0] strb);
      checkOutput("wr_cmd_ready", cmd_ready, 1);
      applyStimulus(1'b1, 1'b1, addr, data, strb);
      M_AXI_awready = 1'b1;
      M_AXI_wready  = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      checkOutput("wr_awvalid", M_AXI_awvalid, 1);
      checkOutput("wr_wvalid", M_AXI_wvalid, 1);
      checkOutput("wr_awaddr", M_AXI_awaddr, addr);
      checkOutput("wr_wdata", M_AXI_wdata, data);
      checkOutput("wr_wstrb", M_AXI_wstrb, strb);
      checkOutput("wr_awprot", M_AXI_awprot, 0);
      checkOutput("wr_busy_ready", cmd_ready, 0);
      step();
      M_AXI_awready = 1'b0;
      M_AXI_wready  = 1'b0;
      checkOutput("wr_aw_drop", M_AXI_awvalid, 0);
      checkOutput("wr_w_drop", M_AXI_wvalid, 0);
      checkOutput("wr_bready", M_AXI_bready, 1);
      M_AXI_bvalid = 1'b1;
      M_AXI_bresp  = 2'b00;
      step();
      M_AXI_bvalid = 1'b0;
      checkOutput("wr_rsp_valid", rsp_valid, 1);
      checkOutput("wr_rsp_write", rsp_write, 1);
      checkOutput("wr_rsp_resp", rsp_resp, 0);
      checkOutput("wr_rsp_rdata", rsp_rdata, 0);
      checkOutput("wr_bready_drop", M_AXI_bready, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      expTxn++;
      checkOutput("wr_rsp_done", rsp_valid, 0);
      checkOutput("wr_txn_count", txn_count, expTxn);
      checkOutput("wr_idle_ready", cmd_ready, 1);
   endtask

   // Read from the register-file slave with zero wait states.
   task automatic doRead(input logic [39:0] addr, input logic [31:0] expData);
      checkOutput("rd_cmd_ready", cmd_ready, 1);
      applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0);
      M_AXI_arready = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      checkOutput("rd_arvalid", M_AXI_arvalid, 1);
      checkOutput("rd_araddr", M_AXI_araddr, addr);
      checkOutput("rd_arprot", M_AXI_arprot, 0);
      checkOutput("rd_no_awvalid", M_AXI_awvalid, 0);
      slaveAddr = M_AXI_araddr;
      step();
      M_AXI_arready = 1'b0;
      checkOutput("rd_ar_drop", M_AXI_arvalid, 0);
      checkOutput("rd_rready", M_AXI_rready, 1);
      M_AXI_rvalid = 1'b1;
      M_AXI_rdata  = rf[slaveAddr[2]];
      M_AXI_rresp  = 2'b00;
      step();
      M_AXI_rvalid = 1'b0;
      M_AXI_rdata  = 32'h0;
      checkOutput("rd_rsp_valid", rsp_valid, 1);
      checkOutput("rd_rsp_rdata", rsp_rdata, expData);
      checkOutput("rd_rsp_resp", rsp_resp, 0);
      checkOutput("rd_rsp_write", rsp_write, 0);
      checkOutput("rd_rready_drop", M_AXI_rready, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      expTxn++;
      checkOutput("rd_rsp_done", rsp_valid, 0);
      checkOutput("rd_txn_count", txn_count, expTxn);
   endtask

   // Directed sequence: reset, basic write/read, slow W channel with a held
   // response, timeout, then reset in the middle of a read.
   initial begin
      rf[0] = 32'hDEADBEEF;
      rf[1] = 32'h76543210;
      slaveAddr = 40'h0;
      axi_areset = 1'b1;
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      rsp_ready     = 1'b0;
      M_AXI_awready = 1'b0;
      M_AXI_wready  = 1'b0;
      M_AXI_bresp   = 2'b00;
      M_AXI_bvalid  = 1'b0;
      M_AXI_arready = 1'b0;
      M_AXI_rdata   = 32'h0;
      M_AXI_rresp   = 2'b00;
      M_AXI_rvalid  = 1'b0;
      repeat (3) step();

      // Reset values.
      checkOutput("rst_cmd_ready", cmd_ready, 0);
      checkOutput("rst_awvalid", M_AXI_awvalid, 0);
      checkOutput("rst_wvalid", M_AXI_wvalid, 0);
      checkOutput("rst_bready", M_AXI_bready, 0);
      checkOutput("rst_arvalid", M_AXI_arvalid, 0);
      checkOutput("rst_rready", M_AXI_rready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_rsp_resp", rsp_resp, 0);
      checkOutput("rst_timeout", timeout, 0);
      checkOutput("rst_txn_count", txn_count, 0);
      axi_areset = 1'b0;
      #1;
      checkOutput("rel_cmd_ready", cmd_ready, 1);
      step();
      checkOutput("rel_cmd_ready_hold", cmd_ready, 1);

      // Zero-wait write, then reads of both registers.
      doWrite(40'h08, 32'hA5A5A5A5, 4'hF);
      doRead(40'h00, 32'hDEADBEEF);
      doRead(40'h04, 32'h76543210);

      // W channel ready 5 cycles after AW; SLVERR response held for 10 cycles
      // while another command waits.
      checkOutput("slow_cmd_ready", cmd_ready, 1);
      applyStimulus(1'b1, 1'b1, 40'h10, 32'hCAFEF00D, 4'hC);
      M_AXI_awready = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      checkOutput("slow_awvalid", M_AXI_awvalid, 1);
      checkOutput("slow_wvalid", M_AXI_wvalid, 1);
      step();
      M_AXI_awready = 1'b0;
      checkOutput("slow_aw_drop", M_AXI_awvalid, 0);
      checkOutput("slow_w_hold", M_AXI_wvalid, 1);
      checkOutput("slow_no_bready", M_AXI_bready, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("slow_w_wait", M_AXI_wvalid, 1);
         checkOutput("slow_wdata_stable", M_AXI_wdata, 32'hCAFEF00D);
         checkOutput("slow_wait_bready", M_AXI_bready, 0);
      end
      M_AXI_wready = 1'b1;
      step();
      M_AXI_wready = 1'b0;
      checkOutput("slow_w_drop", M_AXI_wvalid, 0);
      checkOutput("slow_bready", M_AXI_bready, 1);
      M_AXI_bvalid = 1'b1;
      M_AXI_bresp  = 2'b10;
      step();
      M_AXI_bvalid = 1'b0;
      M_AXI_bresp  = 2'b00;
      checkOutput("slow_one_b", M_AXI_bready, 0);
      applyStimulus(1'b1, 1'b0, 40'h04, 32'h0, 4'h0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_rsp_valid", rsp_valid, 1);
         checkOutput("hold_rsp_resp", rsp_resp, 2'b10);
         checkOutput("hold_rsp_write", rsp_write, 1);
         checkOutput("hold_rsp_rdata", rsp_rdata, 0);
         checkOutput("hold_cmd_ready", cmd_ready, 0);
         checkOutput("hold_no_arvalid", M_AXI_arvalid, 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      expTxn++;
      checkOutput("hold_rsp_done", rsp_valid, 0);
      checkOutput("hold_txn_count", txn_count, expTxn);
      doRead(40'h04, 32'h76543210);

      // B response 40 cycles late with the limit at 16.
      checkOutput("to_cmd_ready", cmd_ready, 1);
      applyStimulus(1'b1, 1'b1, 40'h20, 32'h0BADC0DE, 4'hF);
      M_AXI_awready = 1'b1;
      M_AXI_wready  = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      checkOutput("to_start_clear", timeout, 0);
      step();
      M_AXI_awready = 1'b0;
      M_AXI_wready  = 1'b0;
      checkOutput("to_bready", M_AXI_bready, 1);
      for (int e = 2; e <= 40; e++) begin
         step();
         checkOutput("to_flag", timeout, (e >= 16) ? 64'd1 : 64'd0);
      end
      checkOutput("to_still_waiting", M_AXI_bready, 1);
      M_AXI_bvalid = 1'b1;
      step();
      M_AXI_bvalid = 1'b0;
      checkOutput("to_rsp_valid", rsp_valid, 1);
      checkOutput("to_rsp_resp", rsp_resp, 0);
      checkOutput("to_flag_rsp", timeout, 1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      expTxn++;
      checkOutput("to_txn_count", txn_count, expTxn);
      checkOutput("to_sticky_idle", timeout, 1);

      // Read accepted (clears timeout), then reset while waiting in RD_DATA.
      applyStimulus(1'b1, 1'b0, 40'h00, 32'h0, 4'h0);
      M_AXI_arready = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 40'h0, 32'h0, 4'h0);
      checkOutput("mid_timeout_clear", timeout, 0);
      checkOutput("mid_arvalid", M_AXI_arvalid, 1);
      step();
      M_AXI_arready = 1'b0;
      checkOutput("mid_rready", M_AXI_rready, 1);
      axi_areset   = 1'b1;
      M_AXI_rvalid = 1'b1;
      M_AXI_rdata  = 32'hDEADBEEF;
      step();
      M_AXI_rvalid = 1'b0;
      M_AXI_rdata  = 32'h0;
      expTxn = 16'd0;
      checkOutput("mid_rst_rready", M_AXI_rready, 0);
      checkOutput("mid_rst_arvalid", M_AXI_arvalid, 0);
      checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
      checkOutput("mid_rst_rdata", rsp_rdata, 0);
      checkOutput("mid_rst_txn_count", txn_count, 0);
      checkOutput("mid_rst_cmd_ready", cmd_ready, 0);
      axi_areset = 1'b0;
      #1;
      checkOutput("mid_rel_cmd_ready", cmd_ready, 1);
      doWrite(40'h0C, 32'h12345678, 4'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
